// File: rtl/dmix_cfg_pkg.sv
// dmix_cfg_pkg: register addresses, unity gain and SPI frame FSM states for the mixer config slave
package dmix_cfg_pkg;
  localparam logic [6:0] ADDR_ID = 7'h00;
  localparam logic [6:0] ADDR_STATUS = 7'h01;
  localparam logic [6:0] ADDR_CTRL = 7'h02;
  localparam logic [6:0] ADDR_MUTE = 7'h03;
  localparam logic [6:0] ADDR_VOL_BASE = 7'h10;
  localparam logic [15:0] VOL_UNITY = 16'h8000;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} spi_state_e;
endpackage

// File: rtl/spi_cfg_regs_if.sv
// spi_cfg_regs_if: SPI pin bundle (sck, mosi, ss in; miso out) with master/slave modports
interface spi_cfg_regs_if;
  logic spi_sck_i;
  logic spi_mosi_i;
  logic spi_ss_i;
  logic spi_miso_o;
  modport master(output spi_sck_i, spi_mosi_i, spi_ss_i, input spi_miso_o);
  modport slave(input spi_sck_i, spi_mosi_i, spi_ss_i, output spi_miso_o);
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampling SPI mode-0 slave (pins via spi, status sync in/out, cmd/word strobes, rx_word, ld_data loads miso shifter)
module spi_slave_sync
  import dmix_cfg_pkg::*;
(
  input  logic        clk245760,
  input  logic        rst,
  spi_cfg_regs_if.slave spi,
  input  logic        locked_i,
  input  logic [3:0]  rate_i,
  input  logic [15:0] ld_data,
  output logic        locked_s,
  output logic [3:0]  rate_s,
  output logic        rw,
  output logic        cmd_stb,
  output logic        word_stb,
  output logic [15:0] rx_word
);
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q, lock_q;
  logic [3:0] rate0_q, rate1_q, cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d, tx_q, tx_d;
  logic rw_q, rw_d, miso_q, miso_d, rise, fall;
  spi_state_e state_q, state_d;
  always_comb begin
    rise = sck_q[1] & ~sck_q[2];
    fall = ~sck_q[1] & sck_q[2];
    rx_word = {sh_q[14:0], mosi_q[1]};
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    tx_d = tx_q;
    rw_d = rw_q;
    miso_d = miso_q;
    cmd_stb = 1'b0;
    word_stb = 1'b0;
    if (ss_q[1]) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      miso_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ss_q[2] ? ST_CMD : ST_IDLE;
      cnt_d = '0;
      miso_d = 1'b0;
    end else if (rise) begin
      sh_d = rx_word;
      cnt_d = cnt_q + 4'd1;
      if (state_q == ST_CMD && cnt_q == 4'd7) begin
        cmd_stb = 1'b1;
        state_d = ST_DATA;
        cnt_d = '0;
        rw_d = rx_word[7];
        tx_d = ld_data;
      end else if (state_q == ST_DATA && cnt_q == 4'd15) begin
        word_stb = 1'b1;
        tx_d = ld_data;
      end
    end else if (fall && state_q == ST_DATA) begin
      miso_d = rw_q & tx_q[15];
      tx_d = {tx_q[14:0], 1'b0};
    end
  end
  always_ff @(posedge clk245760)
    if (rst) begin
      sck_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
      lock_q <= '0;
      rate0_q <= '0;
      rate1_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      tx_q <= '0;
      rw_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], spi.spi_sck_i};
      ss_q <= {ss_q[1:0], spi.spi_ss_i};
      mosi_q <= {mosi_q[0], spi.spi_mosi_i};
      lock_q <= {lock_q[0], locked_i};
      rate0_q <= rate_i;
      rate1_q <= rate0_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      rw_q <= rw_d;
      miso_q <= miso_d;
    end
  assign spi.spi_miso_o = miso_q;
  assign rw = rw_q;
  assign locked_s = lock_q[1];
  assign rate_s = rate1_q;
endmodule

// File: rtl/spi_cfg_regs.sv
// spi_cfg_regs: SPI config register file (clk245760/rst, spi pins, locked_i/rate_i status in, vol_o/mute_o/cfg_we_o/cfg_addr_o out)
module spi_cfg_regs
  import dmix_cfg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int NUM_CH_LOG2 = 1,
  parameter logic [15:0] ID_VALUE = 16'hD31C
) (
  input  logic                 clk245760,
  input  logic                 rst,
  spi_cfg_regs_if.slave        spi,
  input  logic                 locked_i,
  input  logic [3:0]           rate_i,
  output logic [NUM_CH*16-1:0] vol_o,
  output logic [NUM_CH-1:0]    mute_o,
  output logic                 cfg_we_o,
  output logic [6:0]           cfg_addr_o
);
  logic locked_s, rw, cmd_stb, word_stb, we, ctrl_q, ctrl_d, cfg_we_q, cfg_we_d;
  logic [3:0] rate_s;
  logic [15:0] rx_word, ld_data;
  logic [6:0] ra, rvi, wvi, addr_q, addr_d, cfg_addr_q, cfg_addr_d;
  logic [NUM_CH-1:0] mute_q, mute_d, mute_o_q, mute_o_d;
  logic [15:0] vol_q [NUM_CH];
  logic [15:0] vol_d [NUM_CH];
  spi_slave_sync u_sync (
    .clk245760(clk245760),
    .rst(rst),
    .spi(spi),
    .locked_i(locked_i),
    .rate_i(rate_i),
    .ld_data(ld_data),
    .locked_s(locked_s),
    .rate_s(rate_s),
    .rw(rw),
    .cmd_stb(cmd_stb),
    .word_stb(word_stb),
    .rx_word(rx_word)
  );
  always_comb begin
    ra = cmd_stb ? rx_word[6:0] : addr_q + 7'd1;
    rvi = ra - ADDR_VOL_BASE;
    wvi = addr_q - ADDR_VOL_BASE;
    we = word_stb & ~rw;
    ld_data = ra == ADDR_ID ? ID_VALUE :
              ra == ADDR_STATUS ? {11'b0, locked_s, locked_s ? rate_s : 4'b0} :
              ra == ADDR_CTRL ? {15'b0, ctrl_q} :
              ra == ADDR_MUTE ? {{(16-NUM_CH){1'b0}}, mute_q} :
              rvi < 7'(NUM_CH) ? vol_q[rvi[NUM_CH_LOG2-1:0]] : 16'h0000;
    addr_d = cmd_stb ? rx_word[6:0] : word_stb ? addr_q + 7'd1 : addr_q;
    ctrl_d = (we && addr_q == ADDR_CTRL) ? rx_word[0] : ctrl_q;
    mute_d = (we && addr_q == ADDR_MUTE) ? rx_word[NUM_CH-1:0] : mute_q;
    for (int i = 0; i < NUM_CH; i++) vol_d[i] = (we && wvi == 7'(i)) ? rx_word : vol_q[i];
    mute_o_d = mute_d | {NUM_CH{ctrl_d}};
    cfg_we_d = we;
    cfg_addr_d = we ? addr_q : cfg_addr_q;
  end
  always_ff @(posedge clk245760)
    if (rst) begin
      addr_q <= '0;
      ctrl_q <= 1'b0;
      mute_q <= '0;
      vol_q <= '{default: VOL_UNITY};
      mute_o_q <= '0;
      cfg_we_q <= 1'b0;
      cfg_addr_q <= '0;
    end else begin
      addr_q <= addr_d;
      ctrl_q <= ctrl_d;
      mute_q <= mute_d;
      vol_q <= vol_d;
      mute_o_q <= mute_o_d;
      cfg_we_q <= cfg_we_d;
      cfg_addr_q <= cfg_addr_d;
    end
  for (genvar n = 0; n < NUM_CH; n++) begin : g_vol
    assign vol_o[n*16 +: 16] = vol_q[n];
  end
  assign mute_o = mute_o_q;
  assign cfg_we_o = cfg_we_q;
  assign cfg_addr_o = cfg_addr_q;
endmodule

// File: tb/tb_spi_cfg_regs.sv
// tb_spi_cfg_regs: table-driven plus randomized SPI frames against a register-map model of spi_cfg_regs
module tb_spi_cfg_regs;
  localparam int HP = 6;
  logic clk245760 = 1'b0;
  logic rst = 1'b1;
  logic locked_i = 1'b0;
  logic [3:0] rate_i = 4'h0;
  logic [31:0] vol_o;
  logic [1:0] mute_o;
  logic cfg_we_o;
  logic [6:0] cfg_addr_o;
  spi_cfg_regs_if spi();
  spi_cfg_regs dut (
    .clk245760(clk245760),
    .rst(rst),
    .spi(spi),
    .locked_i(locked_i),
    .rate_i(rate_i),
    .vol_o(vol_o),
    .mute_o(mute_o),
    .cfg_we_o(cfg_we_o),
    .cfg_addr_o(cfg_addr_o)
  );
  always #20 clk245760 = ~clk245760;
  int cyc = 0, last_rise = 0, pulses = 0, n_cmp = 0, n_bad = 0, nw_t;
  logic [6:0] paddr[$];
  int plat[$];
  logic [15:0] wbuf [4];
  logic [15:0] rbuf [4];
  logic [15:0] m_vol [2];
  logic m_ctrl;
  logic [1:0] m_mute;
  logic [6:0] a_t;
  logic m_t;
  typedef struct {
    bit rd;
    logic [6:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [31:0] exp_vol;
    logic [1:0] exp_mute;
  } vec_t;
  vec_t tbl [17];
  always @(posedge clk245760) cyc++;
  always @(negedge clk245760)
    if (cfg_we_o) begin
      pulses++;
      paddr.push_back(cfg_addr_o);
      plat.push_back(cyc - last_rise);
    end
  initial begin
    repeat (90000) @(posedge clk245760);
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'h00: return 16'hD31C;
      7'h01: return locked_i ? {11'b0, 1'b1, rate_i} : 16'h0000;
      7'h02: return {15'b0, m_ctrl};
      7'h03: return {14'b0, m_mute};
      7'h10, 7'h11: return m_vol[a[0]];
      default: return 16'h0000;
    endcase
  endfunction
  function automatic void m_write(input logic [6:0] a, input logic [15:0] d);
    case (a)
      7'h02: m_ctrl = d[0];
      7'h03: m_mute = d[1:0];
      7'h10, 7'h11: m_vol[a[0]] = d;
      default: ;
    endcase
  endfunction
  function automatic void m_reset();
    m_vol[0] = 16'h8000;
    m_vol[1] = 16'h8000;
    m_ctrl = 1'b0;
    m_mute = 2'b00;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk245760);
    #1;
  endtask
  task automatic bit_out(input logic b, output logic m);
    spi.spi_mosi_i = b;
    wait_cyc(HP);
    m = spi.spi_miso_o;
    spi.spi_sck_i = 1'b1;
    last_rise = cyc;
    wait_cyc(HP);
    spi.spi_sck_i = 1'b0;
  endtask
  task automatic clear_mon();
    pulses = 0;
    paddr.delete();
    plat.delete();
  endtask
  task automatic frame(input bit rd, input logic [6:0] a, input int nw, input int cut);
    logic m, leak;
    logic [7:0] cmd;
    int k;
    cmd = {rd, a};
    k = 0;
    leak = 1'b0;
    clear_mon();
    spi.spi_ss_i = 1'b0;
    wait_cyc(HP);
    for (int i = 7; i >= 0; i--) begin
      bit_out(cmd[i], m);
      leak |= m;
    end
    for (int w = 0; w < nw; w++)
      for (int j = 15; j >= 0; j--)
        if (k != cut) begin
          bit_out(wbuf[w][j], m);
          rbuf[w][j] = m;
          if (!rd) leak |= m;
          k++;
        end
    wait_cyc(HP);
    spi.spi_ss_i = 1'b1;
    wait_cyc(2 * HP);
    check("miso_idle", {31'b0, leak}, 32'h0);
  endtask
  task automatic check_outs();
    check("vol", vol_o, {m_vol[1], m_vol[0]});
    check("mute", {30'b0, mute_o}, {30'b0, m_mute | {2{m_ctrl}}});
  endtask
  task automatic do_write(input logic [6:0] a, input int nw);
    frame(1'b0, a, nw, -1);
    for (int i = 0; i < nw; i++) m_write(7'(a + i), wbuf[i]);
    check("we_count", pulses, nw);
    for (int i = 0; i < paddr.size(); i++) begin
      check("we_addr", {25'b0, paddr[i]}, {25'b0, 7'(a + i)});
      check("we_latency", plat[i], 3);
    end
    check("cfg_addr", {25'b0, cfg_addr_o}, {25'b0, 7'(a + nw - 1)});
    check_outs();
  endtask
  task automatic do_read(input logic [6:0] a, input int nw);
    frame(1'b1, a, nw, -1);
    for (int i = 0; i < nw; i++) check("rdata", {16'b0, rbuf[i]}, {16'b0, m_read(7'(a + i))});
    check("rd_no_we", pulses, 0);
  endtask
  initial begin
    spi.spi_ss_i = 1'b1;
    spi.spi_sck_i = 1'b0;
    spi.spi_mosi_i = 1'b0;
    tbl[0]  = '{1'b1, 7'h00, 16'h0000, 16'hD31C, 32'h8000_8000, 2'b00};
    tbl[1]  = '{1'b0, 7'h11, 16'h4000, 16'h0000, 32'h4000_8000, 2'b00};
    tbl[2]  = '{1'b1, 7'h11, 16'h0000, 16'h4000, 32'h4000_8000, 2'b00};
    tbl[3]  = '{1'b0, 7'h02, 16'h0001, 16'h0000, 32'h4000_8000, 2'b11};
    tbl[4]  = '{1'b1, 7'h02, 16'h0000, 16'h0001, 32'h4000_8000, 2'b11};
    tbl[5]  = '{1'b0, 7'h03, 16'h0002, 16'h0000, 32'h4000_8000, 2'b11};
    tbl[6]  = '{1'b0, 7'h02, 16'h0000, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[7]  = '{1'b1, 7'h03, 16'h0000, 16'h0002, 32'h4000_8000, 2'b10};
    tbl[8]  = '{1'b0, 7'h00, 16'hFFFF, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[9]  = '{1'b1, 7'h00, 16'h0000, 16'hD31C, 32'h4000_8000, 2'b10};
    tbl[10] = '{1'b0, 7'h40, 16'h1111, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[11] = '{1'b1, 7'h40, 16'h0000, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[12] = '{1'b1, 7'h12, 16'h0000, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[13] = '{1'b0, 7'h02, 16'hFFFE, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[14] = '{1'b1, 7'h02, 16'h0000, 16'h0000, 32'h4000_8000, 2'b10};
    tbl[15] = '{1'b0, 7'h03, 16'hFFFF, 16'h0000, 32'h4000_8000, 2'b11};
    tbl[16] = '{1'b0, 7'h10, 16'h0000, 16'h0000, 32'h4000_0000, 2'b11};
    m_reset();
    wait_cyc(5);
    check("rst_vol", vol_o, 32'h8000_8000);
    check("rst_mute", {30'b0, mute_o}, 32'h0);
    check("rst_we", {31'b0, cfg_we_o}, 32'h0);
    check("rst_addr", {25'b0, cfg_addr_o}, 32'h0);
    check("rst_miso", {31'b0, spi.spi_miso_o}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);
    foreach (tbl[v]) begin
      wbuf[0] = tbl[v].data;
      frame(tbl[v].rd, tbl[v].addr, 1, -1);
      if (tbl[v].rd) begin
        check("tbl_rdata", {16'b0, rbuf[0]}, {16'b0, tbl[v].exp_rd});
        check("tbl_rd_we", pulses, 0);
      end else begin
        m_write(tbl[v].addr, tbl[v].data);
        check("tbl_we_count", pulses, 1);
        check("tbl_we_addr", {25'b0, cfg_addr_o}, {25'b0, tbl[v].addr});
        if (plat.size() > 0) check("tbl_we_latency", plat[0], 3);
      end
      check("tbl_vol", vol_o, tbl[v].exp_vol);
      check("tbl_mute", {30'b0, mute_o}, {30'b0, tbl[v].exp_mute});
    end
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'h5678;
    do_write(7'h10, 2);
    check("burst_vol", vol_o, 32'h5678_1234);
    do_read(7'h10, 2);
    check("burst_rd0", {16'b0, rbuf[0]}, 32'h1234);
    check("burst_rd1", {16'b0, rbuf[1]}, 32'h5678);
    locked_i = 1'b1;
    rate_i = 4'h3;
    wait_cyc(6);
    frame(1'b1, 7'h01, 1, -1);
    check("status_locked", {16'b0, rbuf[0]}, 32'h0013);
    locked_i = 1'b0;
    wait_cyc(6);
    frame(1'b1, 7'h01, 1, -1);
    check("status_unlocked", {16'b0, rbuf[0]}, 32'h0000);
    wbuf[0] = 16'hDEAD;
    frame(1'b0, 7'h10, 1, 10);
    check("partial_we", pulses, 0);
    check_outs();
    wbuf[0] = 16'h2222;
    do_write(7'h10, 1);
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'hBBBB;
    do_write(7'h7F, 2);
    clear_mon();
    wbuf[0] = 16'h7777;
    spi.spi_ss_i = 1'b0;
    wait_cyc(HP);
    for (int i = 7; i >= 0; i--) bit_out(i == 4, m_t);
    for (int j = 15; j >= 1; j--) bit_out(wbuf[0][j], m_t);
    spi.spi_mosi_i = wbuf[0][0];
    wait_cyc(HP);
    spi.spi_sck_i = 1'b1;
    spi.spi_ss_i = 1'b1;
    wait_cyc(HP);
    spi.spi_sck_i = 1'b0;
    wait_cyc(2 * HP);
    check("ss_wins_we", pulses, 0);
    check_outs();
    clear_mon();
    spi.spi_ss_i = 1'b0;
    wait_cyc(HP);
    for (int i = 7; i >= 0; i--) bit_out(i == 4, m_t);
    for (int j = 0; j < 5; j++) bit_out(1'b1, m_t);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    m_reset();
    wait_cyc(3);
    clear_mon();
    wbuf[0] = 16'h1357;
    for (int j = 15; j >= 0; j--) bit_out(wbuf[0][j], m_t);
    wait_cyc(HP);
    check("dead_frame_we", pulses, 0);
    check("rst_mid_vol", vol_o, 32'h8000_8000);
    check("rst_mid_mute", {30'b0, mute_o}, 32'h0);
    check("rst_mid_addr", {25'b0, cfg_addr_o}, 32'h0);
    spi.spi_ss_i = 1'b1;
    wait_cyc(2 * HP);
    wbuf[0] = 16'h0BAD;
    do_write(7'h10, 1);
    for (int it = 0; it < 25; it++) begin
      locked_i = 1'($urandom);
      rate_i = 4'($urandom);
      wait_cyc(6);
      case ($urandom_range(0, 7))
        0: a_t = 7'h00;
        1: a_t = 7'h01;
        2: a_t = 7'h02;
        3: a_t = 7'h03;
        4: a_t = 7'h10;
        5: a_t = 7'h11;
        6: a_t = 7'h0F;
        default: a_t = 7'($urandom);
      endcase
      nw_t = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(a_t, nw_t);
      else do_write(a_t, nw_t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
